// File: rtl/counter_mod_updown.sv
// Modulo-(MAX+1) up/down counting stage with wrap/one-shot modes, preset, clamped load
// and a combinational terminal count for cascading. Single-bit state: RUN or HALT.
module counter_mod_updown #(
    parameter int WIDTH = 4,
    parameter int MAX   = 10
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic             i_dir,
    input  logic             i_mode,
    input  logic             i_preset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_out,
    output logic             o_tc,
    output logic             o_wrap,
    output logic             o_done,
    output logic             o_load_err
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_out_nxt;
    logic [WIDTH-1:0] w_term;
    logic [WIDTH-1:0] w_start;
    logic             w_at_term;
    logic             r_wrap;
    logic             w_wrap_nxt;
    logic             r_load_err;
    logic             w_load_err_nxt;

    // Terminal and reload values follow the direction sampled on this edge.
    assign w_term    = i_dir ? MAX_V : '0;
    assign w_start   = i_dir ? '0 : MAX_V;
    assign w_at_term = (r_out == w_term);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (i_load || i_preset) begin
            w_state_nxt = ST_RUN;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_en && w_at_term && i_mode) begin
                        w_state_nxt = ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (!i_mode) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    always_comb begin
        o_tc   = i_en && w_at_term && (r_state == ST_RUN);
        o_done = (r_state == ST_HALT);
    end

    // Count datapath: load beats preset beats stepping; HALT freezes the count.
    always_comb begin
        w_out_nxt      = r_out;
        w_wrap_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;
        if (i_load) begin
            if (i_load_val > MAX_V) begin
                w_out_nxt      = MAX_V;
                w_load_err_nxt = 1'b1;
            end else begin
                w_out_nxt = i_load_val;
            end
        end else if (i_preset) begin
            w_out_nxt = w_start;
        end else if ((r_state == ST_RUN) && i_en) begin
            if (!w_at_term) begin
                w_out_nxt = i_dir ? (r_out + WIDTH'(1)) : (r_out - WIDTH'(1));
            end else if (!i_mode) begin
                w_out_nxt  = w_start;
                w_wrap_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_out      <= '0;
            r_wrap     <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_out      <= w_out_nxt;
            r_wrap     <= w_wrap_nxt;
            r_load_err <= w_load_err_nxt;
        end
    end

    assign o_out      = r_out;
    assign o_wrap     = r_wrap;
    assign o_load_err = r_load_err;

endmodule

// File: tb/tb_counter_mod_updown.sv
// Bench for counter_mod_updown: two cascaded stages, a behavioural model feeding
// expectation queues, and monitors that pop and compare every cycle.
module tb_counter_mod_updown;

    localparam int WIDTH = 4;
    localparam int MAX   = 10;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic             dir = 1'b0;
    logic             mode = 1'b0;
    logic             preset = 1'b0;
    logic             load = 1'b0;
    logic [WIDTH-1:0] load_val = '0;

    logic             s1_dir = 1'b0;
    logic             s1_mode = 1'b0;
    logic             s1_preset = 1'b0;
    logic             s1_load = 1'b0;
    logic [WIDTH-1:0] s1_load_val = '0;

    logic [WIDTH-1:0] out0, out1;
    logic             tc0, tc1, wrap0, wrap1, done0, done1, lerr0, lerr1;

    always #5 clk = ~clk;

    counter_mod_updown #(.WIDTH(WIDTH), .MAX(MAX)) u_stage0 (
        .i_clk(clk), .i_reset(reset), .i_en(en), .i_dir(dir), .i_mode(mode),
        .i_preset(preset), .i_load(load), .i_load_val(load_val),
        .o_out(out0), .o_tc(tc0), .o_wrap(wrap0), .o_done(done0), .o_load_err(lerr0)
    );

    counter_mod_updown #(.WIDTH(WIDTH), .MAX(MAX)) u_stage1 (
        .i_clk(clk), .i_reset(reset), .i_en(tc0), .i_dir(s1_dir), .i_mode(s1_mode),
        .i_preset(s1_preset), .i_load(s1_load), .i_load_val(s1_load_val),
        .o_out(out1), .o_tc(tc1), .o_wrap(wrap1), .o_done(done1), .o_load_err(lerr1)
    );

    typedef struct {
        int out0; bit wrap0; bit done0; bit lerr0;
        int out1; bit wrap1; bit done1; bit lerr1;
    } exp_t;

    typedef struct {
        bit tc0; bit tc1;
    } tc_exp_t;

    exp_t    q_reg[$];
    tc_exp_t q_tc[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: count value, halted flag and last-edge pulses per stage.
    int m_out[2]  = '{0, 0};
    bit m_halt[2] = '{0, 0};
    bit m_wrap[2] = '{0, 0};
    bit m_lerr[2] = '{0, 0};

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int s = 0; s < 2; s++) begin
            m_out[s] = 0; m_halt[s] = 0; m_wrap[s] = 0; m_lerr[s] = 0;
        end
    endfunction

    function automatic void model_step(input int s, input bit e, input bit d, input bit m,
                                       input bit p, input bit l, input int lv);
        int term, start;
        term  = d ? MAX : 0;
        start = d ? 0 : MAX;
        m_wrap[s] = 0;
        m_lerr[s] = 0;
        if (l) begin
            m_halt[s] = 0;
            if (lv > MAX) begin
                m_out[s] = MAX; m_lerr[s] = 1;
            end else begin
                m_out[s] = lv;
            end
        end else if (p) begin
            m_halt[s] = 0;
            m_out[s]  = start;
        end else if (m_halt[s]) begin
            if (!m) m_halt[s] = 0;
        end else if (e) begin
            if (m_out[s] != term)  m_out[s] = d ? m_out[s] + 1 : m_out[s] - 1;
            else if (!m) begin     m_out[s] = start; m_wrap[s] = 1; end
            else                   m_halt[s] = 1;
        end
    endfunction

    task automatic step(input bit rst, input bit e, input bit d, input bit m,
                        input bit p, input bit l, input int lv);
        tc_exp_t t;
        exp_t    x;
        @(negedge clk);
        reset = rst; en = e; dir = d; mode = m; preset = p; load = l;
        load_val = lv[WIDTH-1:0];
        if (rst) model_reset();
        t.tc0 = e && !m_halt[0] && (m_out[0] == (d ? MAX : 0));
        t.tc1 = t.tc0 && !m_halt[1] && (m_out[1] == 0);
        q_tc.push_back(t);
        if (rst) begin
            model_reset();
        end else begin
            model_step(0, e, d, m, p, l, lv);
            model_step(1, t.tc0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        end
        x.out0 = m_out[0]; x.wrap0 = m_wrap[0]; x.done0 = m_halt[0]; x.lerr0 = m_lerr[0];
        x.out1 = m_out[1]; x.wrap1 = m_wrap[1]; x.done1 = m_halt[1]; x.lerr1 = m_lerr[1];
        q_reg.push_back(x);
    endtask

    // Reset asserted between edges must clear everything without waiting for a clock.
    task automatic async_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_out0", 8'(out0), 8'd0);
        check("async_out1", 8'(out1), 8'd0);
        check("async_flags", {4'd0, wrap0, done0, lerr0, wrap1}, 8'd0);
    endtask

    initial begin : tc_monitor
        tc_exp_t t;
        forever begin
            @(negedge clk);
            #2;
            if (q_tc.size() > 0) begin
                t = q_tc.pop_front();
                check("tc0", 8'(tc0), 8'(t.tc0));
                check("tc1", 8'(tc1), 8'(t.tc1));
            end
        end
    end

    initial begin : reg_monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (q_reg.size() > 0) begin
                x = q_reg.pop_front();
                check("out0",  8'(out0),  8'(x.out0));
                check("wrap0", 8'(wrap0), 8'(x.wrap0));
                check("done0", 8'(done0), 8'(x.done0));
                check("lerr0", 8'(lerr0), 8'(x.lerr0));
                check("out1",  8'(out1),  8'(x.out1));
                check("wrap1", 8'(wrap1), 8'(x.wrap1));
                check("done1", 8'(done1), 8'(x.done1));
                check("lerr1", 8'(lerr1), 8'(x.lerr1));
            end
        end
    end

    initial begin : stimulus
        #1;
        check("rst_out0", 8'(out0), 8'd0);
        check("rst_flags0", {5'd0, wrap0, done0, lerr0}, 8'd0);
        check("rst_out1", 8'(out1), 8'd0);
        repeat (2) step(1, 0, 0, 0, 0, 0, 0);

        // down, wrap mode: 10,9,...,0,10,9
        repeat (13) step(0, 1, 0, 0, 0, 0, 0);

        // up, wrap mode from 0
        step(0, 0, 1, 0, 1, 0, 0);
        repeat (12) step(0, 1, 1, 0, 0, 0, 0);

        // one-shot down: halt at 0, en ignored, load resumes
        step(0, 0, 0, 1, 1, 0, 0);
        repeat (15) step(0, 1, 0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 1, 7);
        repeat (9) step(0, 1, 0, 1, 0, 0, 0);
        // HALT exit through mode=0 leaves the count in place
        step(0, 1, 0, 0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0, 0, 0);

        // clamped load, load beats preset
        step(0, 0, 0, 0, 0, 1, 13);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 3);
        step(0, 0, 0, 0, 0, 0, 0);
        // load on a terminal edge suppresses the wrap
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0, 1, 6);

        // async reset at out=5
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 12 && m_out[0] != 5; i++) step(0, 1, 0, 0, 0, 0, 0);
        async_reset();
        step(1, 1, 0, 0, 0, 0, 0);
        repeat (2) step(0, 1, 0, 0, 0, 0, 0);

        // direction toggle at out=4
        step(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 12 && m_out[0] != 4; i++) step(0, 1, 0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 0);

        // cascade from a clean reset
        step(1, 0, 0, 0, 0, 0, 0);
        repeat (34) step(0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 9) < 3),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 19) == 0),
                 int'($urandom_range(0, 15)));
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        step(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3;
        check("queue_drain", 8'(q_reg.size() + q_tc.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
